// File: rtl/camera_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : camera_ctrl
//  Description : Pixel-array camera sequencer. Erases in IDLE, exposes for
//                exp_time*UNIT_CYCLES cycles, then runs an 8-phase two-row
//                readout with ADC strobes. Exposure is adjustable in IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_ctrl #(
  parameter int unsigned EXP_MIN     = 2,
  parameter int unsigned EXP_MAX     = 30,
  parameter int unsigned EXP_DEFAULT = 2,
  parameter int unsigned UNIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       exp_increase,
  input  logic       exp_decrease,
  output logic       erase,
  output logic       expose,
  output logic       nre_1,
  output logic       nre_2,
  output logic       adc,
  output logic [4:0] exp_time,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned c_CNT_W = $clog2(EXP_MAX * UNIT_CYCLES + 1);
  localparam logic [4:0]  c_EXP_MIN     = 5'(EXP_MIN);
  localparam logic [4:0]  c_EXP_MAX     = 5'(EXP_MAX);
  localparam logic [4:0]  c_EXP_DEFAULT = 5'(EXP_DEFAULT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXPOSE  = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_exp_cnt;
  logic [2:0]           r_phase;
  logic [4:0]           r_exp_time;
  // {erase, expose, nre_1, nre_2, adc, busy, frame_done}
  logic [6:0]           r_outs;
  logic [c_CNT_W-1:0]   w_exp_last;

  // Output pattern for a given state/phase. Row enables never overlap and
  // the ADC strobe sits in the middle of each row's three-cycle window.
  function automatic logic [6:0] f_decode(input state_t s, input logic [2:0] ph);
    logic [6:0] v;
    v = 7'b1011000;
    case (s)
      S_EXPOSE:  v = 7'b0111010;
      S_READOUT: begin
        v[6] = 1'b0;
        v[5] = 1'b0;
        v[4] = !(ph <= 3'd2);
        v[3] = !((ph >= 3'd4) && (ph <= 3'd6));
        v[2] = (ph == 3'd1) || (ph == 3'd5);
        v[1] = 1'b1;
        v[0] = (ph == 3'd7);
      end
      default:   v = 7'b1011000;
    endcase
    return v;
  endfunction

  // Last exposure count value; exp_time >= EXP_MIN >= 1 so never underflows.
  assign w_exp_last = c_CNT_W'(32'(r_exp_time) * UNIT_CYCLES - 32'd1);

  // Sequencer: state, counters, exposure setting and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_exp_cnt  <= '0;
      r_phase    <= 3'd0;
      r_exp_time <= c_EXP_DEFAULT;
      r_outs     <= f_decode(S_IDLE, 3'd0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_state   <= S_EXPOSE;
            r_exp_cnt <= '0;
            r_outs    <= f_decode(S_EXPOSE, 3'd0);
          end else if (exp_increase && !exp_decrease) begin
            if (r_exp_time < c_EXP_MAX) r_exp_time <= r_exp_time + 5'd1;
          end else if (exp_decrease && !exp_increase) begin
            if (r_exp_time > c_EXP_MIN) r_exp_time <= r_exp_time - 5'd1;
          end
        end
        S_EXPOSE: begin
          if (r_exp_cnt == w_exp_last) begin
            r_state   <= S_READOUT;
            r_exp_cnt <= '0;
            r_phase   <= 3'd0;
            r_outs    <= f_decode(S_READOUT, 3'd0);
          end else begin
            r_exp_cnt <= r_exp_cnt + c_CNT_ONE;
          end
        end
        S_READOUT: begin
          if (r_phase == 3'd7) begin
            r_state <= S_IDLE;
            r_phase <= 3'd0;
            r_outs  <= f_decode(S_IDLE, 3'd0);
          end else begin
            r_phase <= r_phase + 3'd1;
            r_outs  <= f_decode(S_READOUT, r_phase + 3'd1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_exp_cnt <= '0;
          r_phase   <= 3'd0;
          r_outs    <= f_decode(S_IDLE, 3'd0);
        end
      endcase
    end
  end

  assign {erase, expose, nre_1, nre_2, adc, busy, frame_done} = r_outs;
  assign exp_time = r_exp_time;

endmodule
`default_nettype wire
